cnt_seq_ctrl: RTL and testbench

Run-control sequencer for the team's 74HC161-style 4-bit presettable counter slice (HC161 macro: synchronous active-low parallel load PE, count enables CEP/CET, load has priority over count). The block replaces the hard-wired AND3/INV reload decode of the fixed mod-12 counter with programmable start and top values, start/stop/pause control, one-shot or free-running mode, and wrap reporting. It sits between the control plane and one HC161 instance. MR is shared with the counter's MR.

---
 rtl/cnt_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_cnt_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_seq_ctrl.sv
// Run-control sequencer for one HC161-style 4-bit presettable counter slice.
// Generates PE/CEP/CET/D so the counter runs between a programmable init and
// top value, with start/stop/pause control, one-shot or free-running mode and
// a saturating count of reloads. MR is shared with the counter's own MR.
module cnt_seq_ctrl #(
  parameter int WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              MR,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_top,
  input  logic [3:0]        cfg_init,
  input  logic              cfg_oneshot,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        cnt_q,
  output logic              cnt_pe_n,
  output logic              cnt_cep,
  output logic              cnt_cet,
  output logic [3:0]        cnt_d,
  output logic              busy,
  output logic              wrap,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] top_reg;
  logic [3:0] init_reg;
  logic       oneshot_reg;
  logic       cnt_en;
  logic       hit;
  logic       reload;

  // The counter sits on top_reg; a top of 15 reloads at 15, so the
  // counter's own TC never matters.
  assign hit    = (cnt_q == top_reg);
  // A free-running reload happens in RUN on a hit unless stop overrides it.
  assign reload = (state == S_RUN) && !stop && hit && !oneshot_reg;

  // State register.
  // NOTE: sequential state is always written with <=, so every flop samples
  // values from before the edge regardless of block ordering.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; stop always wins over start and over a top hit.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch forms.
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start && !stop) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = stop ? S_IDLE : S_RUN;
      S_RUN: begin
        if (stop)             state_nxt = S_PAUSE;
        else if (hit && oneshot_reg) state_nxt = S_DONE;
      end
      S_PAUSE: begin
        if (stop)       state_nxt = S_IDLE;
        else if (start) state_nxt = S_RUN;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Counter controls: combinational from state, cnt_q and stop so a hit
  // reloads on the very next edge.
  always_comb begin
    cnt_pe_n = 1'b1;
    cnt_en   = 1'b0;
    unique case (state)
      S_LOAD: cnt_pe_n = 1'b0;
      S_RUN: begin
        if (stop) begin
          cnt_en = 1'b0;
        end else if (hit && oneshot_reg) begin
          cnt_en = 1'b0;
        end else if (hit) begin
          cnt_pe_n = 1'b0;
          cnt_en   = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        cnt_pe_n = 1'b1;
        cnt_en   = 1'b0;
      end
    endcase
  end

  assign cnt_cep   = cnt_en;
  assign cnt_cet   = cnt_en;
  assign cnt_d     = init_reg;
  assign cfg_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Configuration capture; an init above top falls back to 0.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      top_reg     <= 4'd11;
      init_reg    <= 4'd0;
      oneshot_reg <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      top_reg     <= cfg_top;
      init_reg    <= (cfg_init > cfg_top) ? 4'd0 : cfg_init;
      oneshot_reg <= cfg_oneshot;
    end
  end

  // Wrap pulse lands in the cycle the counter shows init after a reload;
  // wrap_cnt restarts at each LOAD and saturates at all-ones.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      wrap     <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      wrap <= reload;
      if (state == S_LOAD) begin
        wrap_cnt <= '0;
      end else if (reload && (wrap_cnt != '1)) begin
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl driving a behavioural HC161 counter slice.
// Inputs change at the falling edge; outputs are compared 1 ns later.
module tb_cnt_seq_ctrl;

  localparam int WRAP_W = 8;

  logic              Clk;
  logic              MR;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [3:0]        cfg_top;
  logic [3:0]        cfg_init;
  logic              cfg_oneshot;
  logic              start;
  logic              stop;
  logic [3:0]        cnt_q;
  logic              cnt_pe_n;
  logic              cnt_cep;
  logic              cnt_cet;
  logic [3:0]        cnt_d;
  logic              busy;
  logic              wrap;
  logic              done;
  logic [WRAP_W-1:0] wrap_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  cnt_seq_ctrl #(.WRAP_W(WRAP_W)) dut (
    .Clk         (Clk),
    .MR          (MR),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_top     (cfg_top),
    .cfg_init    (cfg_init),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
    .cnt_q       (cnt_q),
    .cnt_pe_n    (cnt_pe_n),
    .cnt_cep     (cnt_cep),
    .cnt_cet     (cnt_cet),
    .cnt_d       (cnt_d),
    .busy        (busy),
    .wrap        (wrap),
    .done        (done),
    .wrap_cnt    (wrap_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // HC161 slice: async clear, sync load has priority over count.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR)                      cnt_q <= 4'd0;
    else if (!cnt_pe_n)           cnt_q <= cnt_d;
    else if (cnt_cep && cnt_cet)  cnt_q <= cnt_q + 4'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle: drive this cycle's inputs at the falling edge.
  task automatic cyc(input logic s, input logic p, input logic v);
    @(negedge Clk);
    start     = s;
    stop      = p;
    cfg_valid = v;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".cfg_ready"}, 32'(cfg_ready), 1);
    check({tag, ".pe_n"},      32'(cnt_pe_n),  1);
    check({tag, ".cep"},       32'(cnt_cep),   0);
    check({tag, ".cet"},       32'(cnt_cet),   0);
    check({tag, ".cnt_d"},     32'(cnt_d),     0);
    check({tag, ".busy"},      32'(busy),      0);
    check({tag, ".wrap"},      32'(wrap),      0);
    check({tag, ".done"},      32'(done),      0);
    check({tag, ".wrap_cnt"},  32'(wrap_cnt),  0);
    check({tag, ".cnt_q"},     32'(cnt_q),     0);
  endtask

  task automatic set_cfg(input logic [3:0] top, input logic [3:0] init, input logic os);
    cfg_top     = top;
    cfg_init    = init;
    cfg_oneshot = os;
  endtask

  task automatic abort_run();
    cyc(0, 1, 0);
    cyc(0, 1, 0);
  endtask

  initial begin
    int k;
    MR = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    cfg_valid = 1'b0;
    set_cfg(4'd0, 4'd0, 1'b0);

    // Reset values while MR is held low.
    #2;
    check_reset_outputs("rst");
    @(negedge Clk);
    #2 MR = 1'b1;

    // Default mod-12 free run: 0..11, wrap every 12 cycles.
    cyc(1, 0, 0);
    check("def.idle_busy", 32'(busy), 0);
    cyc(0, 0, 0);
    check("def.load_pe_n", 32'(cnt_pe_n), 0);
    check("def.load_cep",  32'(cnt_cep), 0);
    check("def.load_busy", 32'(busy), 1);
    check("def.load_rdy",  32'(cfg_ready), 0);
    for (int i = 0; i < 36; i++) begin
      cyc(0, 0, 0);
      check("def.cnt_q",    32'(cnt_q), 32'(i % 12));
      check("def.wrap",     32'(wrap), 32'((i > 0) && (i % 12 == 0)));
      check("def.wrap_cnt", 32'(wrap_cnt), 32'(i / 12));
      check("def.pe_n",     32'(cnt_pe_n), 32'(i % 12 != 11));
      check("def.cet",      32'(cnt_cet), 1);
    end
    cyc(0, 1, 0);
    check("def.stop_cep", 32'(cnt_cep), 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    check("def.abort_busy", 32'(busy), 0);

    // One-shot top=9 init=3.
    set_cfg(4'd9, 4'd3, 1'b1);
    cyc(1, 0, 1);
    check("os.cfg_ready", 32'(cfg_ready), 1);
    cyc(0, 0, 0);
    check("os.cnt_d", 32'(cnt_d), 3);
    for (int j = 3; j <= 9; j++) begin
      cyc(0, 0, 0);
      check("os.cnt_q", 32'(cnt_q), 32'(j));
      check("os.cep",   32'(cnt_cep), 32'(j != 9));
      check("os.pe_n",  32'(cnt_pe_n), 1);
      check("os.done0", 32'(done), 0);
    end
    cyc(0, 0, 0);
    check("os.done",      32'(done), 1);
    check("os.done_busy", 32'(busy), 1);
    check("os.hold",      32'(cnt_q), 9);
    cyc(0, 0, 0);
    check("os.done_end", 32'(done), 0);
    check("os.idle",     32'(busy), 0);
    check("os.hold2",    32'(cnt_q), 9);

    // init above top falls back to 0: period 3.
    set_cfg(4'd2, 4'd7, 1'b0);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    check("clamp.cnt_d", 32'(cnt_d), 0);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0);
      check("clamp.cnt_q", 32'(cnt_q), 32'(i % 3));
      check("clamp.wrap",  32'(wrap), 32'((i > 0) && (i % 3 == 0)));
    end
    abort_run();

    // top == init: constant value, wrap continuously high.
    set_cfg(4'd5, 4'd5, 1'b0);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0);
      check("eq.cnt_q", 32'(cnt_q), 5);
      check("eq.wrap",  32'(wrap), 32'(i > 0));
      check("eq.pe_n",  32'(cnt_pe_n), 0);
    end
    abort_run();

    // Pause at 6 and resume; stop exactly at top then resume into a reload.
    set_cfg(4'd11, 4'd0, 1'b0);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0);
      check("pz.cnt_q", 32'(cnt_q), 32'(i));
    end
    cyc(0, 1, 0);
    check("pz.stop_q",   32'(cnt_q), 6);
    check("pz.stop_cep", 32'(cnt_cep), 0);
    cyc(0, 0, 0);
    check("pz.hold",      32'(cnt_q), 6);
    check("pz.hold_cep",  32'(cnt_cep), 0);
    check("pz.hold_busy", 32'(busy), 1);
    cyc(0, 0, 0);
    check("pz.hold2", 32'(cnt_q), 6);
    cyc(1, 0, 0);
    check("pz.resume_cep", 32'(cnt_cep), 0);
    cyc(0, 0, 0);
    check("pz.run_q",   32'(cnt_q), 6);
    check("pz.run_cep", 32'(cnt_cep), 1);
    for (int j = 7; j <= 10; j++) begin
      cyc(0, 0, 0);
      check("pz.cont_q", 32'(cnt_q), 32'(j));
    end
    cyc(0, 1, 0);
    check("pz.top_q",    32'(cnt_q), 11);
    check("pz.top_pe_n", 32'(cnt_pe_n), 1);
    cyc(0, 0, 0);
    check("pz.top_hold", 32'(cnt_q), 11);
    check("pz.no_wrap",  32'(wrap), 0);
    check("pz.no_wcnt",  32'(wrap_cnt), 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    check("pz.res_q",    32'(cnt_q), 11);
    check("pz.res_pe_n", 32'(cnt_pe_n), 0);
    cyc(0, 0, 0);
    check("pz.reload_q", 32'(cnt_q), 0);
    check("pz.wrap",     32'(wrap), 1);
    check("pz.wrap_cnt", 32'(wrap_cnt), 1);
    abort_run();

    // start and stop together in IDLE: no launch.
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    check("ss.busy", 32'(busy), 0);
    check("ss.pe_n", 32'(cnt_pe_n), 1);

    // top=10 init=2 (period 9); config attempt during RUN is refused;
    // 300 wraps saturate wrap_cnt at 255; then async MR at cnt_q=5.
    set_cfg(4'd10, 4'd2, 1'b0);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    check("sat.cnt_d", 32'(cnt_d), 2);
    cyc(0, 0, 0);
    check("sat.first_q", 32'(cnt_q), 2);
    set_cfg(4'd3, 4'd0, 1'b1);
    cyc(0, 0, 1);
    check("sat.cfg_ready", 32'(cfg_ready), 0);
    check("sat.q1",        32'(cnt_q), 3);
    for (int i = 2; i <= 2703; i++) begin
      cyc(0, 0, 0);
      k = i / 9;
      if (k > 255) k = 255;
      check("sat.cnt_q",    32'(cnt_q), 32'(2 + i % 9));
      check("sat.wrap_cnt", 32'(wrap_cnt), 32'(k));
    end
    check("sat.final_q",   32'(cnt_q), 5);
    check("sat.final_cnt", 32'(wrap_cnt), 255);
    check("sat.busy",      32'(busy), 1);
    #2 MR = 1'b0;
    #1;
    check_reset_outputs("mr");
    @(posedge Clk);
    #2 MR = 1'b1;
    cyc(0, 0, 0);
    check("mr.idle", 32'(busy), 0);

    // After reset: defaults again (init 0, top 11).
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    check("post.cnt_d", 32'(cnt_d), 0);
    for (int i = 0; i < 13; i++) begin
      cyc(0, 0, 0);
      check("post.cnt_q", 32'(cnt_q), 32'(i % 12));
    end
    abort_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
